// File: rtl/cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// cache_mem_arbiter
// Shares one physical-memory line port between the I-cache (line reads only)
// and the D-cache (line reads and writebacks). One requester is served at a
// time. The granted request is copied into registers that drive the memory
// port. The memory response goes back to the granted requester only. When
// both caches are waiting, the grant alternates between them.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   icache_read/address      I-cache line read request (held until resp)
//   icache_rdata/resp        line data / completion to the I-cache
//   dcache_read/write        D-cache request (held until resp)
//   dcache_address/wdata     D-cache line address / writeback data
//   dcache_rdata/resp        line data / completion to the D-cache
//   pmem_read/write          memory command from the latched request
//   pmem_address/wdata       memory address / write data from the latch
//   pmem_rdata/resp          memory read data / transfer complete
// ---------------------------------------------------------------------------
module cache_mem_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_read,
    input  logic [ADDR_W-1:0] icache_address,
    output logic [LINE_W-1:0] icache_rdata,
    output logic              icache_resp,
    input  logic              dcache_read,
    input  logic              dcache_write,
    input  logic [ADDR_W-1:0] dcache_address,
    input  logic [LINE_W-1:0] dcache_wdata,
    output logic [LINE_W-1:0] dcache_rdata,
    output logic              dcache_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, COOL} state_e;

    state_e              state_q, state_d;
    logic                last_d_q, last_d_d;      // 1: last completed grant went to the D-cache
    logic                op_read_q, op_read_d;
    logic                op_write_q, op_write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;

    logic d_pend;
    logic grant_i, grant_d;

    assign d_pend  = dcache_read | dcache_write;
    // On contention, give the grant to the requester that was not served last.
    assign grant_i = icache_read & (~d_pend | last_d_q);
    assign grant_d = d_pend & (~icache_read | ~last_d_q);

    assign icache_rdata = pmem_rdata;
    assign dcache_rdata = pmem_rdata;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        op_read_d   = op_read_q;
        op_write_d  = op_write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        pmem_read   = 1'b0;
        pmem_write  = 1'b0;
        icache_resp = 1'b0;
        dcache_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d    = SERVE_I;
                    op_read_d  = 1'b1;
                    op_write_d = 1'b0;
                    addr_d     = icache_address;
                end else if (grant_d) begin
                    state_d    = SERVE_D;
                    // Read and write both high is illegal; it is served as a writeback.
                    op_read_d  = dcache_read & ~dcache_write;
                    op_write_d = dcache_write;
                    addr_d     = dcache_address;
                    wdata_d    = dcache_wdata;
                end
            end
            SERVE_I: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    // A reset in the completion cycle aborts the transfer silently.
                    icache_resp = ~rst;
                    last_d_d    = 1'b0;
                    state_d     = COOL;
                end
            end
            SERVE_D: begin
                pmem_read  = op_read_q;
                pmem_write = op_write_q;
                if (pmem_resp) begin
                    dcache_resp = ~rst;
                    last_d_d    = 1'b1;
                    state_d     = COOL;
                end
            end
            // One dead cycle lets the served cache drop its request before re-arbitration.
            COOL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_d_q   <= 1'b0;
            op_read_q  <= 1'b0;
            op_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            last_d_q   <= last_d_d;
            op_read_q  <= op_read_d;
            op_write_q <= op_write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;
    localparam int LW = 256;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          icache_read = 1'b0;
    logic [AW-1:0] icache_address = '0;
    logic [LW-1:0] icache_rdata;
    logic          icache_resp;
    logic          dcache_read = 1'b0;
    logic          dcache_write = 1'b0;
    logic [AW-1:0] dcache_address = '0;
    logic [LW-1:0] dcache_wdata = '0;
    logic [LW-1:0] dcache_rdata;
    logic          dcache_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata = '0;
    logic          pmem_resp = 1'b0;

    int n_pass = 0;
    int n_tot  = 0;
    bit last_d = 1'b0;   // reference model: did the last completed grant go to the D-cache

    cache_mem_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .icache_read(icache_read), .icache_address(icache_address),
        .icache_rdata(icache_rdata), .icache_resp(icache_resp),
        .dcache_read(dcache_read), .dcache_write(dcache_write),
        .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
        .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int i = 0; i < LW/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic test_reset;
        rst = 1'b1; icache_read = 1'b1; icache_address = 32'h100;
        dcache_read = 1'b1; dcache_write = 1'b0; dcache_address = 32'h200;
        tick;
        n_tot++; if ({pmem_read, pmem_write, icache_resp, dcache_resp} !== 4'b0) $display("FAIL rst_ctrl: got %b want 0000", {pmem_read, pmem_write, icache_resp, dcache_resp}); else n_pass++;
        n_tot++; if (pmem_address !== '0 || pmem_wdata !== '0) $display("FAIL rst_regs: addr %h wdata %h want 0", pmem_address, pmem_wdata); else n_pass++;
        tick;
        rst = 1'b0; last_d = 1'b0;
        #1;
        n_tot++; if ({pmem_read, pmem_write, icache_resp, dcache_resp} !== 4'b0) $display("FAIL rst_after: got %b want 0000", {pmem_read, pmem_write, icache_resp, dcache_resp}); else n_pass++;
        tick;
        n_tot++; if ({pmem_read, pmem_write} !== 2'b10 || pmem_address !== 32'h200) $display("FAIL rst_first_grant: rw %b addr %h want 10 00000200", {pmem_read, pmem_write}, pmem_address); else n_pass++;
        pmem_resp = 1'b1; pmem_rdata = rand_line();
        #1;
        n_tot++; if ({icache_resp, dcache_resp} !== 2'b01 || dcache_rdata !== pmem_rdata) $display("FAIL rst_first_resp: resp %b want 01", {icache_resp, dcache_resp}); else n_pass++;
        tick;
        pmem_resp = 1'b0; icache_read = 1'b0; dcache_read = 1'b0; last_d = 1'b1;
        tick;
    endtask

    task automatic test_icache_read;
        logic [LW-1:0] a5;
        a5 = {(LW/8){8'hA5}};
        icache_read = 1'b1; icache_address = 32'h0000_1000;
        tick;
        for (int c = 1; c <= 3; c++) begin
            #1;
            n_tot++; if ({pmem_read, pmem_write} !== 2'b10 || pmem_address !== 32'h1000 || {icache_resp, dcache_resp} !== 2'b00) $display("FAIL ird_wait%0d: rw %b addr %h resp %b want 10 00001000 00", c, {pmem_read, pmem_write}, pmem_address, {icache_resp, dcache_resp}); else n_pass++;
            tick;
        end
        pmem_resp = 1'b1; pmem_rdata = a5;
        #1;
        n_tot++; if ({icache_resp, dcache_resp} !== 2'b10 || icache_rdata !== a5 || pmem_read !== 1'b1) $display("FAIL ird_resp: resp %b rd %b data %h", {icache_resp, dcache_resp}, pmem_read, icache_rdata); else n_pass++;
        tick;
        pmem_resp = 1'b0; icache_read = 1'b0; last_d = 1'b0;
        #1;
        n_tot++; if ({pmem_read, pmem_write, icache_resp, dcache_resp} !== 4'b0) $display("FAIL ird_cool: got %b want 0000", {pmem_read, pmem_write, icache_resp, dcache_resp}); else n_pass++;
        tick;
    endtask

    task automatic test_dcache_writeback;
        logic [LW-1:0] w;
        w = {(LW/32){32'h1234_5678}};
        dcache_write = 1'b1; dcache_address = 32'h8000_0040; dcache_wdata = w;
        tick;
        for (int c = 1; c <= 5; c++) begin
            if (c == 2) begin dcache_address = 32'hDEAD_0000; dcache_wdata = ~w; end
            if (c == 5) begin pmem_resp = 1'b1; pmem_rdata = rand_line(); end
            #1;
            n_tot++; if ({pmem_read, pmem_write} !== 2'b01 || pmem_address !== 32'h8000_0040 || pmem_wdata !== w) $display("FAIL dwb_hold%0d: rw %b addr %h want 01 80000040", c, {pmem_read, pmem_write}, pmem_address); else n_pass++;
            n_tot++; if ({icache_resp, dcache_resp} !== ((c == 5) ? 2'b01 : 2'b00)) $display("FAIL dwb_resp%0d: got %b", c, {icache_resp, dcache_resp}); else n_pass++;
            tick;
        end
        pmem_resp = 1'b0; dcache_write = 1'b0; last_d = 1'b1;
        tick;
    endtask

    task automatic test_contention;
        bit win_d;
        int lat;
        rst = 1'b1;
        tick;
        rst = 1'b0; last_d = 1'b0;
        icache_read = 1'b1; icache_address = 32'h3000;
        dcache_read = 1'b1; dcache_write = 1'b0; dcache_address = 32'h4000;
        for (int k = 0; k < 4; k++) begin
            win_d = !last_d;
            lat = $urandom_range(1, 3);
            tick;
            for (int c = 1; c <= lat; c++) begin
                if (c == lat) begin pmem_resp = 1'b1; pmem_rdata = rand_line(); end
                #1;
                n_tot++; if (pmem_address !== (win_d ? 32'h4000 : 32'h3000) || {pmem_read, pmem_write} !== 2'b10) $display("FAIL cont_grant%0d: addr %h rw %b want %s", k, pmem_address, {pmem_read, pmem_write}, win_d ? "D" : "I"); else n_pass++;
                if (c == lat) begin
                    n_tot++; if ({icache_resp, dcache_resp} !== (win_d ? 2'b01 : 2'b10)) $display("FAIL cont_resp%0d: got %b", k, {icache_resp, dcache_resp}); else n_pass++;
                end else tick;
            end
            tick;
            pmem_resp = 1'b0; last_d = win_d;
            #1;
            n_tot++; if ({pmem_read, pmem_write, icache_resp, dcache_resp} !== 4'b0) $display("FAIL cont_gap1_%0d: got %b", k, {pmem_read, pmem_write, icache_resp, dcache_resp}); else n_pass++;
            tick;
            n_tot++; if ({pmem_read, pmem_write, icache_resp, dcache_resp} !== 4'b0) $display("FAIL cont_gap2_%0d: got %b", k, {pmem_read, pmem_write, icache_resp, dcache_resp}); else n_pass++;
        end
        icache_read = 1'b0; dcache_read = 1'b0;
        tick;
        tick;
    endtask

    task automatic test_stray_illegal;
        logic [LW-1:0] w;
        pmem_resp = 1'b1;
        #1;
        n_tot++; if ({icache_resp, dcache_resp} !== 2'b00) $display("FAIL stray_idle: got %b want 00", {icache_resp, dcache_resp}); else n_pass++;
        tick;
        pmem_resp = 1'b0;
        #1;
        n_tot++; if ({pmem_read, pmem_write} !== 2'b00) $display("FAIL stray_stay_idle: got %b want 00", {pmem_read, pmem_write}); else n_pass++;
        w = rand_line();
        dcache_read = 1'b1; dcache_write = 1'b1; dcache_address = 32'h5000; dcache_wdata = w;
        tick;
        n_tot++; if ({pmem_read, pmem_write} !== 2'b01 || pmem_address !== 32'h5000 || pmem_wdata !== w) $display("FAIL illegal_rw: rw %b addr %h want 01 00005000", {pmem_read, pmem_write}, pmem_address); else n_pass++;
        pmem_resp = 1'b1;
        #1;
        n_tot++; if ({icache_resp, dcache_resp} !== 2'b01) $display("FAIL illegal_resp: got %b want 01", {icache_resp, dcache_resp}); else n_pass++;
        tick;
        dcache_read = 1'b0; dcache_write = 1'b0; last_d = 1'b1;
        #1;
        n_tot++; if ({pmem_read, pmem_write, icache_resp, dcache_resp} !== 4'b0) $display("FAIL stray_cool: got %b want 0000", {pmem_read, pmem_write, icache_resp, dcache_resp}); else n_pass++;
        tick;
        pmem_resp = 1'b0;
    endtask

    task automatic test_reset_mid;
        icache_read = 1'b1; icache_address = 32'h6000;
        tick;
        n_tot++; if (pmem_read !== 1'b1) $display("FAIL rmid_grant: rd %b want 1", pmem_read); else n_pass++;
        tick;
        rst = 1'b1; pmem_resp = 1'b1; pmem_rdata = rand_line();
        #1;
        n_tot++; if ({icache_resp, dcache_resp} !== 2'b00) $display("FAIL rmid_resp: got %b want 00", {icache_resp, dcache_resp}); else n_pass++;
        tick;
        rst = 1'b0; pmem_resp = 1'b0; icache_read = 1'b0; last_d = 1'b0;
        #1;
        n_tot++; if ({pmem_read, pmem_write, icache_resp, dcache_resp} !== 4'b0) $display("FAIL rmid_after: got %b want 0000", {pmem_read, pmem_write, icache_resp, dcache_resp}); else n_pass++;
        tick;
    endtask

    // Random traffic against a model that only knows the arbitration rule,
    // the fixed 3-cycle turnaround and that the served request is frozen.
    task automatic test_random;
        bit ip, dp, dr, dw, win_d;
        logic [AW-1:0] ia, da, ea;
        logic [LW-1:0] dwd;
        logic [1:0] erw;
        int lat, op;
        ip = 0; dp = 0; dr = 0; dw = 0; ia = '0; da = '0; dwd = '0;
        for (int it = 0; it < 40; it++) begin
            if (!ip && $urandom_range(0, 1) == 1) begin ip = 1; ia = $urandom; end
            if (!dp && $urandom_range(0, 1) == 1) begin
                dp = 1; da = $urandom; op = $urandom_range(0, 2);
                dr = (op != 1); dw = (op != 0); dwd = rand_line();
            end
            icache_read = ip; icache_address = ia;
            dcache_read = dp & dr; dcache_write = dp & dw; dcache_address = da; dcache_wdata = dwd;
            #1;
            n_tot++; if ({pmem_read, pmem_write, icache_resp, dcache_resp} !== 4'b0) $display("FAIL rnd_idle%0d: got %b", it, {pmem_read, pmem_write, icache_resp, dcache_resp}); else n_pass++;
            if (!ip && !dp) begin tick; continue; end
            win_d = dp && (!ip || !last_d);
            ea  = win_d ? da : ia;
            erw = win_d ? {dr & ~dw, dw} : 2'b10;
            lat = $urandom_range(1, 5);
            tick;
            for (int c = 1; c <= lat; c++) begin
                if (c == 2) begin
                    if (win_d) dcache_address = $urandom; else icache_address = $urandom;
                end
                if (c == lat) begin pmem_resp = 1'b1; pmem_rdata = rand_line(); end
                #1;
                n_tot++; if ({pmem_read, pmem_write} !== erw || pmem_address !== ea || (win_d && pmem_wdata !== dwd)) $display("FAIL rnd_port%0d_%0d: rw %b addr %h want %b %h", it, c, {pmem_read, pmem_write}, pmem_address, erw, ea); else n_pass++;
                if (c == lat) begin
                    n_tot++; if ({icache_resp, dcache_resp} !== (win_d ? 2'b01 : 2'b10) || (win_d ? dcache_rdata : icache_rdata) !== pmem_rdata) $display("FAIL rnd_resp%0d: got %b want %b", it, {icache_resp, dcache_resp}, win_d ? 2'b01 : 2'b10); else n_pass++;
                end else begin
                    n_tot++; if ({icache_resp, dcache_resp} !== 2'b00) $display("FAIL rnd_early%0d_%0d: got %b want 00", it, c, {icache_resp, dcache_resp}); else n_pass++;
                    tick;
                end
            end
            tick;
            pmem_resp = ($urandom_range(0, 1) == 1);
            if (win_d) begin dp = 0; dcache_read = 1'b0; dcache_write = 1'b0; end
            else begin ip = 0; icache_read = 1'b0; end
            last_d = win_d;
            #1;
            n_tot++; if ({pmem_read, pmem_write, icache_resp, dcache_resp} !== 4'b0) $display("FAIL rnd_cool%0d: got %b", it, {pmem_read, pmem_write, icache_resp, dcache_resp}); else n_pass++;
            tick;
            pmem_resp = 1'b0;
        end
        icache_read = 1'b0; dcache_read = 1'b0; dcache_write = 1'b0;
        tick;
    endtask

    initial begin
        test_reset;
        test_icache_read;
        test_dcache_writeback;
        test_contention;
        test_stray_illegal;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Arbiter that shares the single physical-memory port (cacheline adaptor side) between the instruction cache and the data cache. It accepts whole-line read requests from the I-cache and line read/write requests from the D-cache. It grants one requester at a time, forwards a registered copy of its request to physical memory, and returns the response to that requester only. When both requesters are pending, grant alternates between them so that neither starves.

## Interface
- LINE_W, 256, cacheline width in bits
- ADDR_W, 32, address width in bits
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- icache_read  in  1  I-cache line read request; held until icache_resp
- icache_address  in  ADDR_W  I-cache line address
- icache_rdata  out  LINE_W  line data to I-cache
- icache_resp  out  1  I-cache request complete
- dcache_read  in  1  D-cache line read request; held until dcache_resp
- dcache_write  in  1  D-cache line writeback request; held until dcache_resp
- dcache_address  in  ADDR_W  D-cache line address
- dcache_wdata  in  LINE_W  writeback data
- dcache_rdata  out  LINE_W  line data to D-cache
- dcache_resp  out  1  D-cache request complete
- pmem_read  out  1  memory line read
- pmem_write  out  1  memory line write
- pmem_address  out  ADDR_W  memory address
- pmem_wdata  out  LINE_W  memory write data
- pmem_rdata  in  LINE_W  memory read data
- pmem_resp  in  1  memory transfer complete

## Operation
- The FSM has four states: IDLE, SERVE_I, SERVE_D, COOL.
- **IDLE**
  - No pending request: stay in IDLE.
  - Only the I-cache is pending: latch its request, go to SERVE_I.
  - Only the D-cache is pending: latch its request, go to SERVE_D.
  - Both are pending: grant the requester that is not `last_grant`.
- **Latched request registers**
  - Fields: op_read, op_write, address, wdata.
  - They are loaded only on the IDLE→SERVE_* transition.
  - pmem_* outputs are driven from these registers, so a change on requester inputs mid-transfer has no effect.
- **D-cache read and write both high:** treat as a write (protocol violation). op_read=0, op_write=1.
- **SERVE_I**
  - Outputs: pmem_read=1, pmem_write=0.
  - On pmem_resp: icache_resp=1 combinationally in the same cycle, `last_grant`←I, go to COOL.
- **SERVE_D**
  - Outputs: pmem_read=op_read, pmem_write=op_write.
  - On pmem_resp: dcache_resp=1 in the same cycle, `last_grant`←D, go to COOL.
- **COOL**
  - pmem_read and pmem_write are both 0.
  - Unconditional transition to IDLE.
  - Its purpose is to give the served requester one cycle to drop its request before re-arbitration, which prevents double service.
- **Read data**
  - icache_rdata=pmem_rdata and dcache_rdata=pmem_rdata (passthrough).
  - Each is meaningful only when its resp is high.
- **pmem_resp outside SERVE_*** (IDLE or COOL): ignored; no resp is asserted.
- **Resp exclusivity:** icache_resp and dcache_resp are never high in the same cycle.

## Timing
- **Reset values**
  - State=IDLE, `last_grant`=I (so the first contended grant goes to the D-cache).
  - Latched registers = 0.
  - pmem_read=pmem_write=0, icache_resp=dcache_resp=0, pmem_address=0, pmem_wdata=0.
- **Reset mid-transfer**
  - Takes effect at the next edge: state→IDLE and pmem_read/write drop in the following cycle.
  - No resp is asserted in the reset cycle or later for the aborted request.
- **Grant latency:** a request sampled in IDLE at edge t has pmem_read/write asserted in cycle t+1.
- **Response latency:** resp is asserted in the same cycle as pmem_resp (zero added latency).
- **Back-to-back:**
  - pmem_resp in cycle t, then COOL in t+1, then IDLE in t+2.
  - The next pmem request is asserted in cycle t+3.
  - Minimum overhead is 3 cycles per transfer beyond memory latency.
- **Held outputs:** pmem_read/pmem_write stay held continuously from grant until and including the pmem_resp cycle.

## Test plan
- **Reset:** assert rst 2 cycles with both caches requesting. Required: all outputs 0 during reset and one cycle after, then the D-cache is granted first.
- **Lone I-cache read:**
  - Stimulus: icache_read=1, addr 0x0000_1000; memory responds 4 cycles later with rdata=0xA5…A5.
  - Required: pmem_read=1, pmem_address=0x1000; icache_resp=1 for exactly one cycle with icache_rdata=0xA5…A5; dcache_resp=0.
- **D-cache writeback:**
  - Stimulus: dcache_write=1, addr 0x8000_0040, wdata=0x1234…; the requester changes address to 0xDEAD_0000 mid-transfer.
  - Required: pmem_write=1, pmem_address stays 0x8000_0040 throughout, pmem_wdata unchanged, dcache_resp on pmem_resp.
- **Contention alternation:**
  - Stimulus: both requesters held continuously for 4 transfers.
  - Required: grant order D, I, D, I; each resp is followed by ≥2 cycles with pmem_read=pmem_write=0.
- **Stray and illegal inputs:**
  - pmem_resp pulsed in IDLE: required, no resp.
  - dcache_read=dcache_write=1: required, pmem_write=1 and pmem_read=0.
- **Reset mid-transfer:**
  - Stimulus: rst=1 while in SERVE_I, with pmem_resp arriving the same cycle.
  - Required: no icache_resp after the reset edge; pmem_read=0 in the next cycle.
